// File: rtl/id_ex_elastic_reg_pkg.sv
// Shared types for the ID/EX elastic register: FSM states, control-bit layout,
// default-width payload and the buffer-occupancy transition function.
package id_ex_elastic_reg_pkg;

    // Occupancy of the two-slot buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Control bits that must read as zero whenever a slot holds a bubble
    localparam int CTRL_W      = 5;
    localparam int CTRL_WB_EN  = 0;
    localparam int CTRL_MEM_R  = 1;
    localparam int CTRL_MEM_W  = 2;
    localparam int CTRL_BR     = 3;
    localparam int CTRL_S      = 4;

    // Default widths, used for the default payload layout
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_AW  = 4;
    localparam int DEF_CMD_W   = 4;
    localparam int DEF_SHIFT_W = 12;
    localparam int DEF_IMM_W   = 24;
    localparam int DEF_STAT_W  = 4;

    // Payload at default widths; the top builds the same layout from its own parameters
    typedef struct packed {
        logic [CTRL_W-1:0]             ctrl;
        logic                          imm;
        logic [DEF_CMD_W-1:0]          cmd;
        logic [DEF_DATA_W-1:0]         pc;
        logic [DEF_DATA_W-1:0]         val_rn;
        logic [DEF_DATA_W-1:0]         val_rm;
        logic [DEF_SHIFT_W-1:0]        shift;
        logic signed [DEF_IMM_W-1:0]   simm;
        logic [DEF_REG_AW-1:0]         rn;
        logic [DEF_REG_AW-1:0]         rm;
        logic [DEF_REG_AW-1:0]         dest;
        logic [DEF_STAT_W-1:0]         status;
    } payload_t;

    // Occupancy update; flush wins over any handshake in the same cycle
    function automatic state_t next_state(state_t cur, logic flush, logic accept, logic take);
        state_t nxt;
        nxt = cur;
        if (flush) begin
            nxt = EMPTY;
        end else begin
            case (cur)
                EMPTY:   if (accept) nxt = ONE;
                ONE: begin
                    if (accept && !take)      nxt = FULL;
                    else if (take && !accept) nxt = EMPTY;
                end
                FULL:    if (take) nxt = ONE;
                default: nxt = EMPTY;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/id_ex_elastic_reg_if.sv
// Decode-to-execute bus: upstream handshake/payload, write-back snoop and
// downstream handshake/payload. slave is the register's view.
interface id_ex_elastic_reg_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 4,
    parameter int CMD_W   = 4,
    parameter int SHIFT_W = 12,
    parameter int IMM_W   = 24,
    parameter int STAT_W  = 4
);
    logic                      flush;
    logic                      freeze;

    logic                      up_valid;
    logic                      up_ready;
    logic                      up_wb_en;
    logic                      up_mem_r;
    logic                      up_mem_w;
    logic                      up_br;
    logic                      up_s;
    logic                      up_imm;
    logic                      up_two_src;
    logic [CMD_W-1:0]          up_cmd;
    logic [DATA_W-1:0]         up_pc;
    logic [DATA_W-1:0]         up_val_rn;
    logic [DATA_W-1:0]         up_val_rm;
    logic [SHIFT_W-1:0]        up_shift;
    logic signed [IMM_W-1:0]   up_simm;
    logic [REG_AW-1:0]         up_rn;
    logic [REG_AW-1:0]         up_rm;
    logic [REG_AW-1:0]         up_dest;
    logic [STAT_W-1:0]         up_status;

    logic                      wb_en;
    logic [REG_AW-1:0]         wb_dest;
    logic [DATA_W-1:0]         wb_value;

    logic                      dn_valid;
    logic                      dn_ready;
    logic                      dn_wb_en;
    logic                      dn_mem_r;
    logic                      dn_mem_w;
    logic                      dn_br;
    logic                      dn_s;
    logic                      dn_imm;
    logic [CMD_W-1:0]          dn_cmd;
    logic [DATA_W-1:0]         dn_pc;
    logic [DATA_W-1:0]         dn_val_rn;
    logic [DATA_W-1:0]         dn_val_rm;
    logic [SHIFT_W-1:0]        dn_shift;
    logic signed [IMM_W-1:0]   dn_simm;
    logic [REG_AW-1:0]         dn_rn;
    logic [REG_AW-1:0]         dn_rm;
    logic [REG_AW-1:0]         dn_dest;
    logic [STAT_W-1:0]         dn_status;

    modport master (
        output flush, freeze,
        output up_valid, up_wb_en, up_mem_r, up_mem_w, up_br, up_s, up_imm, up_two_src,
        output up_cmd, up_pc, up_val_rn, up_val_rm, up_shift, up_simm,
        output up_rn, up_rm, up_dest, up_status,
        output wb_en, wb_dest, wb_value,
        output dn_ready,
        input  up_ready,
        input  dn_valid, dn_wb_en, dn_mem_r, dn_mem_w, dn_br, dn_s, dn_imm,
        input  dn_cmd, dn_pc, dn_val_rn, dn_val_rm, dn_shift, dn_simm,
        input  dn_rn, dn_rm, dn_dest, dn_status
    );

    modport slave (
        input  flush, freeze,
        input  up_valid, up_wb_en, up_mem_r, up_mem_w, up_br, up_s, up_imm, up_two_src,
        input  up_cmd, up_pc, up_val_rn, up_val_rm, up_shift, up_simm,
        input  up_rn, up_rm, up_dest, up_status,
        input  wb_en, wb_dest, wb_value,
        input  dn_ready,
        output up_ready,
        output dn_valid, dn_wb_en, dn_mem_r, dn_mem_w, dn_br, dn_s, dn_imm,
        output dn_cmd, dn_pc, dn_val_rn, dn_val_rm, dn_shift, dn_simm,
        output dn_rn, dn_rm, dn_dest, dn_status
    );
endinterface

// File: rtl/id_ex_elastic_reg_slot.sv
// One buffer slot: payload register plus valid bit. clear beats load; a held
// valid entry, or an entry being loaded, picks up matching write-back values.
module id_ex_slot
    import id_ex_elastic_reg_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  REG_AW = 4,
    parameter type pay_t  = payload_t
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  pay_t              d_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    input  logic [DATA_W-1:0] wb_value_i,
    output logic              valid_o,
    output pay_t              q_o
);
    logic valid_q, valid_d;
    pay_t pay_q, pay_d;

    // rn and rm are patched independently so both can update together
    function automatic pay_t snoop(pay_t p, logic en, logic [REG_AW-1:0] dst,
                                   logic [DATA_W-1:0] val);
        pay_t r;
        r = p;
        if (en && (p.rn == dst)) r.val_rn = val;
        if (en && (p.rm == dst)) r.val_rm = val;
        return r;
    endfunction

    // Next slot contents: clear leaves a bubble with zeroed control bits
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (clear_i) begin
            valid_d    = 1'b0;
            pay_d.ctrl = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pay_d   = snoop(d_i, wb_en_i, wb_dest_i, wb_value_i);
        end else if (valid_q) begin
            pay_d   = snoop(pay_q, wb_en_i, wb_dest_i, wb_value_i);
        end
    end

    // Slot register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = pay_q;
endmodule

// File: rtl/id_ex_elastic_reg.sv
// ID/EX pipeline register as a two-entry skid buffer. up_ready depends only on
// occupancy and freeze, so execute backpressure never reaches decode
// combinationally. The main slot drives the execute-side outputs directly.
module id_ex_elastic_reg
    import id_ex_elastic_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 4,
    parameter int CMD_W   = 4,
    parameter int SHIFT_W = 12,
    parameter int IMM_W   = 24,
    parameter int STAT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    id_ex_elastic_reg_if.slave  bus
);
    typedef struct packed {
        logic [CTRL_W-1:0]         ctrl;
        logic                      imm;
        logic [CMD_W-1:0]          cmd;
        logic [DATA_W-1:0]         pc;
        logic [DATA_W-1:0]         val_rn;
        logic [DATA_W-1:0]         val_rm;
        logic [SHIFT_W-1:0]        shift;
        logic signed [IMM_W-1:0]   simm;
        logic [REG_AW-1:0]         rn;
        logic [REG_AW-1:0]         rm;
        logic [REG_AW-1:0]         dest;
        logic [STAT_W-1:0]         status;
    } slot_t;

    state_t state_q;
    slot_t  up_pay, main_d, main_q, skid_q;
    logic   main_vld, skid_vld;
    logic   main_load, main_clear, skid_load, skid_clear;
    logic   accept, take;

    assign bus.up_ready = !bus.freeze && (state_q != FULL);
    assign accept       = bus.up_valid && bus.up_ready;
    assign take         = main_vld && bus.dn_ready;

    // Pack the decode-side fields into the slot layout
    always_comb begin
        up_pay                   = '0;
        up_pay.ctrl[CTRL_WB_EN]  = bus.up_wb_en;
        up_pay.ctrl[CTRL_MEM_R]  = bus.up_mem_r;
        up_pay.ctrl[CTRL_MEM_W]  = bus.up_mem_w;
        up_pay.ctrl[CTRL_BR]     = bus.up_br;
        up_pay.ctrl[CTRL_S]      = bus.up_s;
        up_pay.imm               = bus.up_imm;
        up_pay.cmd               = bus.up_cmd;
        up_pay.pc                = bus.up_pc;
        up_pay.val_rn            = bus.up_val_rn;
        up_pay.val_rm            = bus.up_val_rm;
        up_pay.shift             = bus.up_shift;
        up_pay.simm              = bus.up_simm;
        up_pay.rn                = bus.up_rn;
        up_pay.rm                = bus.up_rm;
        up_pay.dest              = bus.up_dest;
        up_pay.status            = bus.up_status;
    end

    // Slot steering: new entries go to main unless main is held, then skid;
    // on a take from FULL the skid entry moves forward and skid empties
    always_comb begin
        main_load  = 1'b0;
        main_clear = bus.flush;
        skid_load  = 1'b0;
        skid_clear = bus.flush;
        main_d     = up_pay;
        if (!bus.flush) begin
            case (state_q)
                EMPTY: main_load = accept;
                ONE: begin
                    main_load  = accept && take;
                    skid_load  = accept && !take;
                    main_clear = take && !accept;
                end
                FULL: begin
                    main_load  = take;
                    skid_clear = take;
                    main_d     = skid_q;
                end
                default: main_clear = 1'b1;
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= next_state(state_q, bus.flush, accept, take);
    end

    id_ex_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW), .pay_t(slot_t)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load_i     (main_load),
        .clear_i    (main_clear),
        .d_i        (main_d),
        .wb_en_i    (bus.wb_en),
        .wb_dest_i  (bus.wb_dest),
        .wb_value_i (bus.wb_value),
        .valid_o    (main_vld),
        .q_o        (main_q)
    );

    id_ex_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW), .pay_t(slot_t)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load_i     (skid_load),
        .clear_i    (skid_clear),
        .d_i        (up_pay),
        .wb_en_i    (bus.wb_en),
        .wb_dest_i  (bus.wb_dest),
        .wb_value_i (bus.wb_value),
        .valid_o    (skid_vld),
        .q_o        (skid_q)
    );

    assign bus.dn_valid  = main_vld;
    assign bus.dn_wb_en  = main_q.ctrl[CTRL_WB_EN];
    assign bus.dn_mem_r  = main_q.ctrl[CTRL_MEM_R];
    assign bus.dn_mem_w  = main_q.ctrl[CTRL_MEM_W];
    assign bus.dn_br     = main_q.ctrl[CTRL_BR];
    assign bus.dn_s      = main_q.ctrl[CTRL_S];
    assign bus.dn_imm    = main_q.imm;
    assign bus.dn_cmd    = main_q.cmd;
    assign bus.dn_pc     = main_q.pc;
    assign bus.dn_val_rn = main_q.val_rn;
    assign bus.dn_val_rm = main_q.val_rm;
    assign bus.dn_shift  = main_q.shift;
    assign bus.dn_simm   = main_q.simm;
    assign bus.dn_rn     = main_q.rn;
    assign bus.dn_rm     = main_q.rm;
    assign bus.dn_dest   = main_q.dest;
    assign bus.dn_status = main_q.status;
endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Directed bench for id_ex_elastic_reg with a queue scoreboard of expected entries.
module tb_id_ex_elastic_reg;
    import id_ex_elastic_reg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_elastic_reg_if bus ();

    id_ex_elastic_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] vrn;
        logic [31:0] vrm;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic        wb;
    } ent_t;

    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [31:0] pc, input logic [3:0] rn,
                       input logic [3:0] rm, input logic [31:0] vrn, input logic [31:0] vrm,
                       input logic wb);
        bus.up_valid   = v;
        bus.up_pc      = pc;
        bus.up_rn      = rn;
        bus.up_rm      = rm;
        bus.up_val_rn  = vrn;
        bus.up_val_rm  = vrm;
        bus.up_wb_en   = wb;
        bus.up_mem_r   = wb;
        bus.up_mem_w   = 1'b0;
        bus.up_br      = 1'b0;
        bus.up_s       = wb;
        bus.up_imm     = 1'b0;
        bus.up_two_src = 1'b1;
        bus.up_cmd     = pc[5:2];
        bus.up_shift   = pc[11:0];
        bus.up_simm    = -24'sd4;
        bus.up_dest    = rn + 4'd1;
        bus.up_status  = 4'h0;
    endtask

    task automatic wbk(input logic en, input logic [3:0] d, input logic [31:0] v);
        bus.wb_en    = en;
        bus.wb_dest  = d;
        bus.wb_value = v;
    endtask

    // One clock: check outputs at negedge against the model, update the model
    // with this cycle's handshake/snoop/flush, then step past the rising edge.
    task automatic cyc();
        logic exp_rdy;
        ent_t e;
        @(negedge clk);
        exp_rdy = !bus.freeze && (sb.size() < 2);
        chk("up_ready", bus.up_ready, exp_rdy);
        chk("dn_valid", bus.dn_valid, sb.size() != 0);
        if (!bus.dn_valid) chk("bubble_wb_en", bus.dn_wb_en, 0);
        if (sb.size() != 0 && bus.dn_ready) begin
            e = sb.pop_front();
            chk("dn_pc", bus.dn_pc, e.pc);
            chk("dn_val_rn", bus.dn_val_rn, e.vrn);
            chk("dn_val_rm", bus.dn_val_rm, e.vrm);
            chk("dn_wb_en", bus.dn_wb_en, e.wb);
        end
        if (bus.flush) begin
            sb.delete();
        end else begin
            if (bus.up_valid && exp_rdy) begin
                e.pc  = bus.up_pc;
                e.vrn = bus.up_val_rn;
                e.vrm = bus.up_val_rm;
                e.rn  = bus.up_rn;
                e.rm  = bus.up_rm;
                e.wb  = bus.up_wb_en;
                sb.push_back(e);
            end
            if (bus.wb_en) begin
                foreach (sb[i]) begin
                    if (sb[i].rn == bus.wb_dest) sb[i].vrn = bus.wb_value;
                    if (sb[i].rm == bus.wb_dest) sb[i].vrm = bus.wb_value;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        bus.flush  = 1'b0;
        bus.freeze = 1'b0;
        bus.dn_ready = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0);
        wbk(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        // reset state
        chk("rst_dn_valid", bus.dn_valid, 0);
        chk("rst_dn_wb_en", bus.dn_wb_en, 0);
        chk("rst_dn_pc", bus.dn_pc, 0);
        chk("rst_up_ready", bus.up_ready, 1);
        chk("rst_state", 64'(dut.state_q), 64'(EMPTY));
        rst = 1'b1;
        cyc();

        // streaming
        bus.dn_ready = 1'b1;
        put(1, 32'h10, 4'd1, 4'd2, 32'h100, 32'h200, 1); cyc();
        put(1, 32'h14, 4'd1, 4'd2, 32'h101, 32'h201, 0); cyc();
        put(1, 32'h18, 4'd1, 4'd2, 32'h102, 32'h202, 1); cyc();
        put(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // backpressure
        bus.dn_ready = 1'b0;
        put(1, 32'h20, 4'd2, 4'd4, 32'h120, 32'h220, 1); cyc();
        put(1, 32'h24, 4'd2, 4'd4, 32'h124, 32'h224, 0); cyc();
        put(1, 32'h28, 4'd2, 4'd4, 32'h128, 32'h228, 1); cyc();
        chk("bp_state_full", 64'(dut.state_q), 64'(FULL));
        chk("bp_up_ready", bus.up_ready, 0);
        chk("bp_head_pc", bus.dn_pc, 32'h20);
        bus.dn_ready = 1'b1;
        cyc(); cyc();
        put(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();

        // flush with full buffer, then flush concurrent with an accept
        bus.dn_ready = 1'b0;
        put(1, 32'h30, 4'd5, 4'd6, 32'h130, 32'h230, 1); cyc();
        put(1, 32'h34, 4'd5, 4'd6, 32'h134, 32'h234, 1); cyc();
        bus.flush = 1'b1;
        put(1, 32'h38, 4'd5, 4'd6, 32'h138, 32'h238, 1); cyc();
        bus.flush = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0);
        chk("flush_full_dn_valid", bus.dn_valid, 0);
        chk("flush_full_dn_wb_en", bus.dn_wb_en, 0);
        chk("flush_full_state", 64'(dut.state_q), 64'(EMPTY));
        cyc();
        put(1, 32'h3C, 4'd5, 4'd6, 32'h13C, 32'h23C, 1); cyc();
        bus.flush = 1'b1;
        put(1, 32'h40, 4'd5, 4'd6, 32'h140, 32'h240, 1); cyc();
        bus.flush = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0);
        chk("flush_acc_dn_valid", bus.dn_valid, 0);
        chk("flush_acc_dn_wb_en", bus.dn_wb_en, 0);
        cyc(); cyc();

        // snoop while held in main
        put(1, 32'h50, 4'd3, 4'd5, 32'h5, 32'h55, 1); cyc();
        put(0, 0, 0, 0, 0, 0, 0);
        wbk(1, 4'd3, 32'hAA); cyc();
        wbk(0, 0, 0);
        chk("snoop_val_rn", bus.dn_val_rn, 32'hAA);
        chk("snoop_val_rm", bus.dn_val_rm, 32'h55);
        bus.dn_ready = 1'b1;
        cyc(); cyc();

        // snoop on the entry accepted into skid, then on the skid-to-main move
        bus.dn_ready = 1'b0;
        put(1, 32'h60, 4'd1, 4'd2, 32'h11, 32'h22, 0); cyc();
        put(1, 32'h64, 4'd6, 4'd7, 32'h66, 32'h77, 1);
        wbk(1, 4'd7, 32'hBB); cyc();
        put(0, 0, 0, 0, 0, 0, 0);
        wbk(0, 0, 0);
        chk("skid_val_rm", dut.skid_q.val_rm, 32'hBB);
        chk("skid_head_val_rm", bus.dn_val_rm, 32'h22);
        bus.dn_ready = 1'b1;
        wbk(1, 4'd6, 32'hCC); cyc();
        wbk(0, 0, 0);
        chk("move_snoop_rn", bus.dn_val_rn, 32'hCC);
        chk("move_snoop_rm", bus.dn_val_rm, 32'hBB);
        cyc(); cyc();

        // freeze in ONE with draining head
        bus.dn_ready = 1'b0;
        put(1, 32'h70, 4'd8, 4'd9, 32'h170, 32'h270, 1); cyc();
        bus.freeze   = 1'b1;
        bus.dn_ready = 1'b1;
        put(1, 32'h74, 4'd8, 4'd9, 32'h174, 32'h274, 1); cyc(); cyc();
        chk("freeze_state", 64'(dut.state_q), 64'(EMPTY));
        bus.freeze = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0); cyc();

        // asynchronous reset mid-transfer
        bus.dn_ready = 1'b0;
        put(1, 32'h80, 4'd1, 4'd1, 32'h180, 32'h280, 1); cyc();
        put(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dn_valid", bus.dn_valid, 0);
        chk("arst_dn_wb_en", bus.dn_wb_en, 0);
        chk("arst_dn_pc", bus.dn_pc, 0);
        chk("arst_state", 64'(dut.state_q), 64'(EMPTY));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.dn_ready = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_elastic_reg.md
# id_ex_elastic_reg

Parametrised ID/EX pipeline register with a two-entry elastic (skid) buffer between the decode stage and the execute stage. It replaces the fixed 32-bit freeze/flush register with a valid/ready handshake, so execute can apply backpressure without a combinational path back to decode. It also snoops the write-back bus and patches held operand values, so an instruction stalled in the buffer never carries a stale Val_Rn/Val_Rm.

## Interface

Parameters:
- DATA_W, 32: width of PC, Val_Rn, Val_Rm and the WB value.
- REG_AW, 4: register index width (Rn, Rm, Dest, WB dest).
- CMD_W, 4: execute command width.
- SHIFT_W, 12: shift-operand width.
- IMM_W, 24: signed branch immediate width.
- STAT_W, 4: status-flag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all held entries.
- freeze  in  1  blocks acceptance from decode.
- up_valid  in  1  decode presents an entry.
- up_ready  out  1  buffer can accept.
- up_wb_en, up_mem_r, up_mem_w, up_br, up_s, up_imm, up_two_src  in  1 each  control bits.
- up_cmd  in  CMD_W  execute command.
- up_pc, up_val_rn, up_val_rm  in  DATA_W  PC and operand values.
- up_shift  in  SHIFT_W  shift operand.
- up_simm  in  IMM_W  signed immediate.
- up_rn, up_rm, up_dest  in  REG_AW  register indices.
- up_status  in  STAT_W  status flags.
- wb_en  in  1  write-back strobe.
- wb_dest  in  REG_AW  write-back register index.
- wb_value  in  DATA_W  write-back value.
- dn_valid  out  1  head entry valid.
- dn_ready  in  1  execute consumes the head entry.
- dn_*  out  same widths as up_*  head entry fields (no two_src output; rn/rm are exported for forwarding).

## Operation

- Handshake signals:
  - accept = up_valid & up_ready.
  - take = dn_valid & dn_ready.
  - up_ready = !freeze & (state != FULL).
- Storage: two slots, main (drives dn_*) and skid.
- States and transitions:
  - EMPTY: on accept, go to ONE (entry into main).
  - ONE:
    - accept & take: stay in ONE; main is replaced.
    - accept & !take: go to FULL; entry into skid.
    - take & !accept: go to EMPTY.
  - FULL: on take, go to ONE; skid moves to main and skid is cleared.
- flush takes priority over accept, take and snoop. On the next edge:
  - state is EMPTY.
  - All control bits in both slots are 0.
- Bubble rule: whenever a slot is invalid, its control bits (wb_en, mem_r, mem_w, br, s) are 0. dn_* control outputs are therefore 0 while dn_valid=0.
- WB snoop, applied when wb_en=1 to every valid slot, and to the entry being accepted in that cycle:
  - If rn == wb_dest, val_rn is replaced by wb_value.
  - If rm == wb_dest, val_rm is replaced by wb_value.
  - rn and rm are compared independently, so both may update in the same cycle.
  - When a slot is moved from skid to main, snoop is applied during the move.
- Reset values: every output register, dn_valid and state are 0. up_ready follows its formula, so it is 1 after reset when freeze=0.

## Timing

- Latency: accept at edge N gives dn_valid=1 after edge N.
- Throughput: one entry per cycle while dn_ready=1.
- up_ready has no combinational dependency on dn_ready. It depends only on state and freeze.
- The snoop update is visible on dn_val_rn/dn_val_rm one cycle after the wb_en cycle.
- flush and reset:
  - A flush and an accept in the same cycle: the incoming entry is dropped.
  - A reset assertion mid-transfer clears everything immediately, without waiting for clk.
- freeze=1 in FULL state has no extra effect; take still drains the buffer.

## Structure

- Shared package:
  - Payload struct typedef parametrised by the widths above.
  - State enum {EMPTY, ONE, FULL}.
  - Localparam for control-bit positions.
- Sub-module `id_ex_slot`: one payload register plus valid bit, with load, clear and snoop logic. It is instantiated twice (main, skid).

## Test plan

- Reset and streaming:
  - Stimulus: reset, then up_valid=1 with up_pc=0x10, 0x14, 0x18 on consecutive cycles, dn_ready=1.
  - Required: dn_valid=1 from cycle 1; dn_pc shows 0x10, 0x14, 0x18; up_ready stays 1.
- Backpressure:
  - Stimulus: dn_ready=0 while pushing 0x20, 0x24, 0x28.
  - Required: state FULL after two accepts; up_ready=0; 0x28 held off. Releasing dn_ready drains 0x20, 0x24, then 0x28, with none lost or duplicated.
- Flush with a full buffer plus a concurrent accept:
  - Required: dn_valid=0 and dn_wb_en=0 next cycle; the accepted entry is absent.
- Snoop while held:
  - Stimulus: entry with rn=3 and val_rn=0x5 stalled; wb_en=1, wb_dest=3, wb_value=0xAA.
  - Required: dn_val_rn=0xAA next cycle; dn_val_rm is unchanged when rm≠3.
- Snoop on an accepting entry in the skid slot:
  - Stimulus: wb_dest equals the incoming rm.
  - Required: the captured val_rm equals wb_value.
- Freeze:
  - Stimulus: freeze=1 with up_valid=1 in state ONE and dn_ready=1.
  - Required: up_ready=0; the head drains and the buffer goes EMPTY; no new entry is accepted.
